// File: rtl/align_shifter_pipe.sv
// align_shifter_pipe
//
// Pipelined mantissa alignment shifter. The left-justified mantissa is placed
// in an OUT_W-bit frame and arithmetic-right-shifted by in_shift, with vacated
// high bits filled by in_sig. Shifts of OUT_W or more saturate to all in_sig.
// A zero mantissa always yields a zero result with out_zero set. The SH_W
// binary shift levels are spread over STAGES registered stages, the first
// ceil(SH_W/STAGES) levels in stage 0 and so on. Valid/ready on both sides.
//
// Optional feature macro: ALIGN_SHIFTER_STICKY_EN
//   defined     : sticky logic and per-stage sticky registers are built;
//                 out_sticky is the OR of all 1-bits shifted below bit 0.
//   not defined : out_sticky is tied to 0, no sticky registers exist.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input transaction present
//   in_ready   block accepts input this cycle (independent of in_valid)
//   in_data    IN_W-bit mantissa, left-justified into the output frame
//   in_shift   SH_W-bit right-shift amount
//   in_sig     fill value for vacated high bits
//   out_valid  result present
//   out_ready  consumer accepts result this cycle
//   out_data   OUT_W-bit shifted result, held while stalled
//   out_sticky OR of bits shifted past the LSB
//   out_zero   in_data was all zeros

module align_shifter_pipe #(
    parameter int IN_W   = 25,
    parameter int OUT_W  = 49,
    parameter int SH_W   = 6,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [SH_W-1:0]   in_shift,
    input  logic              in_sig,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sticky,
    output logic              out_zero
);

    localparam int LPS   = (SH_W + STAGES - 1) / STAGES;
    localparam int SHR_N = (STAGES > 1) ? STAGES - 1 : 1;

    // Apply shift levels [lo, hi) of sh to d, filling with s. A level whose
    // weight reaches OUT_W shifts everything out and leaves all-fill.
    function automatic logic [OUT_W-1:0] shr_levels(
        input logic [OUT_W-1:0] d,
        input logic             s,
        input logic [SH_W-1:0]  sh,
        input int               lo,
        input int               hi
    );
        logic [OUT_W-1:0] r;
        logic [OUT_W-1:0] ones;
        r    = d;
        ones = '1;
        for (int j = 0; j < SH_W; j++) begin
            if (j >= lo && j < hi && sh[j]) begin
                r = (r >> (2**j)) | (s ? ~(ones >> (2**j)) : '0);
            end
        end
        return r;
    endfunction

`ifdef ALIGN_SHIFTER_STICKY_EN
    // OR of the bits each level in [lo, hi) pushes below bit 0. Fill bits can
    // only fall off the bottom when the total shift exceeds OUT_W, and then
    // the non-zero mantissa already forces sticky high, so no masking needed.
    function automatic logic sticky_levels(
        input logic [OUT_W-1:0] d,
        input logic             s,
        input logic [SH_W-1:0]  sh,
        input int               lo,
        input int               hi
    );
        logic [OUT_W-1:0] r;
        logic [OUT_W-1:0] ones;
        logic             stk;
        r    = d;
        ones = '1;
        stk  = 1'b0;
        for (int j = 0; j < SH_W; j++) begin
            if (j >= lo && j < hi && sh[j]) begin
                stk = stk | (|(r & ~(ones << (2**j))));
                r   = (r >> (2**j)) | (s ? ~(ones >> (2**j)) : '0);
            end
        end
        return stk;
    endfunction
`endif

    logic               v_s   [STAGES];
    logic [OUT_W-1:0]   dat_s [STAGES];
    logic               sig_s [STAGES];
    logic               zro_s [STAGES];
    logic [SH_W-1:0]    sh_s  [SHR_N];
`ifdef ALIGN_SHIFTER_STICKY_EN
    logic               stk_s [STAGES];
`endif

    logic [STAGES-1:0]  load;

    // A stage may load when it is empty or its content moves on this cycle.
    // Walk from the output back so each stage sees its successor's decision.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !v_s[k] || nxt;
            nxt     = load[k];
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * LPS;
        localparam int HI = (LO + LPS > SH_W) ? SH_W : LO + LPS;

        logic              vin;
        logic [OUT_W-1:0]  src;
        logic              sig_src;
        logic              zro_src;
        logic [SH_W-1:0]   sh_src;
        logic [OUT_W-1:0]  dat_d;

        logic              v_q;
        logic [OUT_W-1:0]  dat_q;
        logic              sig_q;
        logic              zro_q;

        if (k == 0) begin : g_head
            logic is_zero;
            assign is_zero = (in_data == '0);
            assign vin     = in_valid;
            assign src     = {in_data, {(OUT_W-IN_W){1'b0}}};
            // Killing the fill for a zero mantissa keeps the whole path zero.
            assign sig_src = in_sig & ~is_zero;
            assign zro_src = is_zero;
            assign sh_src  = in_shift;
        end else begin : g_body
            assign vin     = v_s[k-1];
            assign src     = dat_s[k-1];
            assign sig_src = sig_s[k-1];
            assign zro_src = zro_s[k-1];
            assign sh_src  = sh_s[k-1];
        end

        assign dat_d = shr_levels(src, sig_src, sh_src, LO, HI);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                dat_q <= '0;
                sig_q <= 1'b0;
                zro_q <= 1'b0;
            end else if (load[k]) begin
                v_q <= vin;
                if (vin) begin
                    dat_q <= dat_d;
                    sig_q <= sig_src;
                    zro_q <= zro_src;
                end
            end
        end

        assign v_s[k]   = v_q;
        assign dat_s[k] = dat_q;
        assign sig_s[k] = sig_q;
        assign zro_s[k] = zro_q;

        // The shift amount is only needed by later stages.
        if (k < STAGES - 1) begin : g_sh
            logic [SH_W-1:0] sh_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_q <= '0;
                end else if (load[k] && vin) begin
                    sh_q <= sh_src;
                end
            end
            assign sh_s[k] = sh_q;
        end

`ifdef ALIGN_SHIFTER_STICKY_EN
        logic stk_src;
        logic stk_d;
        logic stk_q;
        if (k == 0) begin : g_stk_head
            assign stk_src = 1'b0;
        end else begin : g_stk_body
            assign stk_src = stk_s[k-1];
        end
        assign stk_d = stk_src | sticky_levels(src, sig_src, sh_src, LO, HI);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stk_q <= 1'b0;
            end else if (load[k] && vin) begin
                stk_q <= stk_d;
            end
        end
        assign stk_s[k] = stk_q;
`endif
    end

    assign out_valid = v_s[STAGES-1];
    assign out_data  = dat_s[STAGES-1];
    assign out_zero  = zro_s[STAGES-1];
`ifdef ALIGN_SHIFTER_STICKY_EN
    assign out_sticky = stk_s[STAGES-1];
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_align_shifter_pipe.sv
module tb_align_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_data = '0;
    logic [5:0]  in_shift = '0;
    logic        in_sig = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [48:0] out_data;
    logic        out_sticky;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

`ifdef ALIGN_SHIFTER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct packed {
        logic [48:0] d;
        logic        s;
        logic        z;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    align_shifter_pipe #(
        .IN_W(25), .OUT_W(49), .SH_W(6), .STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shift(in_shift), .in_sig(in_sig),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sticky(out_sticky), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a result is consumed on the edge following a
    // negedge where out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", out_data);
            end else begin
                mon_e = q.pop_front();
                chk("out_data",   64'(out_data),   64'(mon_e.d));
                chk("out_sticky", 64'(out_sticky), 64'(mon_e.s & STK));
                chk("out_zero",   64'(out_zero),   64'(mon_e.z));
            end
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input logic [24:0] d, input logic [5:0] sh, input logic sg,
                        input logic [48:0] ed, input logic es, input logic ez);
        int n;
        exp_t e;
        n = 0;
        in_data  = d;
        in_shift = sh;
        in_sig   = sg;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end else begin
            e.d = ed;
            e.s = es;
            e.z = ez;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 25'($urandom);
        in_shift = 6'($urandom);
        in_sig   = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_out_data",   64'(out_data),   64'd0);
        chk("rst_out_sticky", 64'(out_sticky), 64'd0);
        chk("rst_out_zero",   64'(out_zero),   64'd0);
        @(posedge clk);
        #1;

        // Directed vectors streamed back to back with out_ready high.
        out_ready = 1'b1;
        send(25'h1000000, 6'd4,  1'b1, 49'h1_F000_0000_0000, 1'b0, 1'b0);
        send(25'h0000001, 6'd24, 1'b0, 49'h0_0000_0000_0001, 1'b0, 1'b0);
        send(25'h0000001, 6'd25, 1'b0, 49'h0_0000_0000_0000, 1'b1, 1'b0);
        send(25'h1FFFFFF, 6'd63, 1'b1, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(25'h1FFFFFF, 6'd63, 1'b0, 49'h0_0000_0000_0000, 1'b1, 1'b0);
        send(25'h0000000, 6'd10, 1'b1, 49'h0_0000_0000_0000, 1'b0, 1'b1);
        send(25'h1234567, 6'd0,  1'b0, 49'h1_2345_6700_0000, 1'b0, 1'b0);
        send(25'h0000001, 6'd49, 1'b0, 49'h0_0000_0000_0000, 1'b1, 1'b0);
        send(25'h1800000, 6'd48, 1'b1, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(25'h1800000, 6'd48, 1'b0, 49'h0_0000_0000_0001, 1'b1, 1'b0);
        send(25'h0000000, 6'd63, 1'b1, 49'h0_0000_0000_0000, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two accepts fill the pipe, the third waits.
        out_ready = 1'b0;
        send(25'h1000000, 6'd1, 1'b0, 49'h0_8000_0000_0000, 1'b0, 1'b0);
        send(25'h1000000, 6'd2, 1'b0, 49'h0_4000_0000_0000, 1'b0, 1'b0);
        in_data  = 25'h1000000;
        in_shift = 6'd3;
        in_sig   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready),  64'd0);
        chk("bp_out_valid",    64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data",  64'(out_data), 64'h0_8000_0000_0000);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", 64'(in_ready),  64'd1);
        chk("bp_drain_1",       64'(out_valid), 64'd1);
        if (in_ready) begin
            mon_e.d = 49'h0_2000_0000_0000;
            mon_e.s = 1'b0;
            mon_e.z = 1'b0;
            q.push_back(mon_e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_2", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("bp_drain_3", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Reset mid-flight discards both queued transactions.
        out_ready = 1'b0;
        send(25'h0000001, 6'd0,  1'b0, 49'h0_0000_0100_0000, 1'b0, 1'b0);
        send(25'h0000000, 6'd5,  1'b1, 49'h0_0000_0000_0000, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid",  64'(out_valid),  64'd0);
        chk("mid_rst_out_data",   64'(out_data),   64'd0);
        chk("mid_rst_out_zero",   64'(out_zero),   64'd0);
        chk("mid_rst_out_sticky", 64'(out_sticky), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready",  64'(in_ready),  64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(25'h1234567, 6'd8, 1'b0, 49'h0_0123_4567_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_cycle2", 64'(out_valid), 64'd1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/align_shifter_pipe.md
# align_shifter_pipe

Pipelined, parametrised mantissa alignment shifter for the L1 operand preparer. It takes a left-justified mantissa, arithmetic-right-shifts it by an exponent difference, and fills vacated high bits with the sign. Zero mantissas produce a zero result. It saturates shifts of OUT_W or more and reports a sticky bit for bits shifted past the LSB. Valid/ready handshakes on both sides let it sit between the exponent-compare stage and the adder without a global stall.

## Interface
- IN_W, 25, input mantissa width
- OUT_W, 49, output width; OUT_W > IN_W
- SH_W, 6, shift-amount width; 2^SH_W may exceed OUT_W
- STAGES, 2, pipeline register stages, 1 ≤ STAGES ≤ SH_W
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block accepts input this cycle
- in_data  input  IN_W  mantissa, left-justified into the output frame
- in_shift  input  SH_W  right-shift amount
- in_sig  input  1  fill value for vacated high bits
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  OUT_W  shifted result
- out_sticky  output  1  OR of all 1-bits shifted below bit 0
- out_zero  output  1  in_data was all zeros

## Operation
- Frame: ex = {in_data, (OUT_W-IN_W)'b0}. out_data = ex >> in_shift, with bits [OUT_W-1 : OUT_W-in_shift] forced to in_sig.
- Zero input (in_data == 0): out_data = 0, out_sticky = 0, out_zero = 1, regardless of in_sig and in_shift.
- Saturation: in_shift ≥ OUT_W gives out_data = all in_sig and out_sticky = |in_data.
- Sticky: the OR of ex bits [in_shift-1:0]. It can only be 1 when in_shift > OUT_W-IN_W.
- Shift decomposition: the log2 shifter's SH_W binary levels are split across STAGES registered stages. The first ceil(SH_W/STAGES) levels go in stage 0, and so on. Sig, zero flag and partial sticky travel with the data.
- Handshake: a transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
  - Each stage k holds a valid bit v[k].
  - Stage k loads when !v[k] or stage k+1 takes its content. The last stage is taken when out_ready is high.
  - in_ready = !v[0] || (stage 0 advancing). in_ready must not depend combinationally on in_valid.
- Ordering: results leave strictly in acceptance order; none are dropped or duplicated.
- Capacity: STAGES transactions in flight.
- out_valid = v[STAGES-1]. out_data, out_sticky and out_zero stay stable while out_valid && !out_ready.
- Simultaneous accept and drain in a full pipe is allowed: throughput stays at 1 per cycle.

## Timing
- Latency: STAGES cycles from the accept edge to out_valid, with no backpressure.
- Throughput: 1 result per cycle while out_ready = 1.
- Reset (asserted asynchronously, released synchronously by the environment):
  - All v[k] = 0, so out_valid = 0.
  - out_data = 0, out_sticky = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after release.
- Reset mid-operation: all in-flight transactions are discarded with no partial output. The first post-reset result is the first post-reset accept.
- in_data, in_shift and in_sig are sampled only on the accept edge; they are don't-care otherwise.

## Configuration
- ALIGN_SHIFTER_STICKY_EN defined: sticky logic and its per-stage registers are built; out_sticky behaves as above.
- Not defined: out_sticky is tied to 0 and no sticky registers exist. Every other output is identical to the defined case, cycle for cycle.

## Test plan
All scenarios use defaults (IN_W=25, OUT_W=49, SH_W=6, STAGES=2) and the macro defined.
- Basic sign fill: in_data=25'h1000000, in_shift=4, in_sig=1, out_ready=1 → two cycles later out_data has bits [48:44]=1 and the rest 0; sticky=0, zero=0.
- Sticky boundary: in_data=25'h1, sig=0.
  - shift=24 → out_data=49'h1, sticky=0.
  - shift=25 → out_data=0, sticky=1.
- Saturation: in_data=25'h1FFFFFF, shift=63, sig=1 → out_data=all ones, sticky=1. Repeat with sig=0 → out_data=0, sticky=1.
- Zero input: in_data=0, shift=10, sig=1 → out_data=0, sticky=0, zero=1.
- Backpressure: out_ready=0 while in_valid=1 streams shifts 1,2,3.
  - in_ready drops after 2 accepts.
  - out_data is held stable.
  - Raising out_ready yields results for shifts 1,2,3 in order on consecutive cycles.
- Reset mid-flight: accept 2 transactions, then assert rst for 1 cycle → out_valid=0 and outputs 0 immediately (asynchronous). After release the next accept emerges with 2-cycle latency; no stale result appears.
